// File: rtl/serial_pkg.sv
// Shared definitions for the bit-serial arithmetic family (adder, and later
// subtractor/multiplier): FSM state encodings and the default operand width.
package serial_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } ser_state_e;

    localparam int SER_WIDTH_DEF = 8;

endpackage : serial_pkg

// File: rtl/full_adder.sv
// Single-bit full adder cell: combinational sum and carry of three input bits.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic carry
);

    assign sum   = a ^ b ^ cin;
    assign carry = (a & b) | (cin & (a ^ b));

endmodule : full_adder

// File: rtl/serial_adder.sv
// Bit-serial adder: one full_adder cell plus a carry flop adds two WIDTH-bit
// operands LSB first, one bit per clock, with a start/busy/done handshake.
module serial_adder
    import serial_pkg::*;
#(
    parameter int WIDTH = SER_WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    ser_state_e       state_r;
    ser_state_e       state_s;
    logic [WIDTH-1:0] sa_r;
    logic [WIDTH-1:0] sb_r;
    logic [WIDTH-1:0] ss_r;
    logic [WIDTH-1:0] sum_r;
    logic [CW-1:0]    cnt_r;
    logic             c_r;
    logic             cout_r;
    logic             busy_r;
    logic             done_r;
    logic             load_s;
    logic             shift_s;
    logic             finish_s;
    logic             fa_sum_s;
    logic             fa_carry_s;

    full_adder u_fa (
        .a     (sa_r[0]),
        .b     (sb_r[0]),
        .cin   (c_r),
        .sum   (fa_sum_s),
        .carry (fa_carry_s)
    );

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state and datapath control decode
    always_comb begin
        state_s  = state_r;
        load_s   = 1'b0;
        shift_s  = 1'b0;
        finish_s = 1'b0;
        case (state_r)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    load_s  = 1'b1;
                    state_s = ST_SHIFT;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                shift_s = 1'b1;
                if (cnt_r == LAST_BIT) begin
                    finish_s = 1'b1;
                    state_s  = ST_DONE;
                end else begin
                    state_s  = ST_SHIFT;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Operand/partial-sum shifting, carry loop, counter and result capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sa_r   <= {WIDTH{1'b0}};
            sb_r   <= {WIDTH{1'b0}};
            ss_r   <= {WIDTH{1'b0}};
            c_r    <= 1'b0;
            cnt_r  <= {CW{1'b0}};
            sum_r  <= {WIDTH{1'b0}};
            cout_r <= 1'b0;
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else begin
            if (load_s) begin
                sa_r  <= a;
                sb_r  <= b;
                c_r   <= cin;
                cnt_r <= {CW{1'b0}};
            end else if (shift_s) begin
                sa_r  <= {1'b0, sa_r[WIDTH-1:1]};
                sb_r  <= {1'b0, sb_r[WIDTH-1:1]};
                ss_r  <= {fa_sum_s, ss_r[WIDTH-1:1]};
                c_r   <= fa_carry_s;
                cnt_r <= cnt_r + CW'(1);
            end
            // The final bit is folded straight into sum so done and the result coincide
            if (finish_s) begin
                sum_r  <= {fa_sum_s, ss_r[WIDTH-1:1]};
                cout_r <= fa_carry_s;
            end
            busy_r <= (state_s == ST_SHIFT);
            done_r <= finish_s;
        end
    end

    assign busy = busy_r;
    assign done = done_r;
    assign sum  = sum_r;
    assign cout = cout_r;

endmodule : serial_adder

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder at WIDTH=8 and WIDTH=5: drivers push the
// expected {cout,sum} per accepted start, monitors pop and compare on done.
module tb_serial_adder;

    logic       clk;
    logic       rst_n;
    logic       start8, cin8, busy8, done8, cout8;
    logic [7:0] a8, b8, sum8;
    logic       start5, cin5, busy5, done5, cout5;
    logic [4:0] a5, b5, sum5;

    int n_checks = 0;
    int n_fail   = 0;

    logic [8:0] q8[$];
    logic [5:0] q5[$];
    logic [8:0] held8 = 9'd0;
    logic [5:0] held5 = 6'd0;

    serial_adder #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .cin(cin8),
        .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
    );

    serial_adder #(.WIDTH(5)) dut5 (
        .clk(clk), .rst_n(rst_n), .start(start5), .a(a5), .b(b5), .cin(cin5),
        .busy(busy5), .done(done5), .sum(sum5), .cout(cout5)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // WIDTH=8 monitor: result on done, exclusivity, result hold otherwise
    always @(negedge clk) begin
        if (!rst_n) begin
            held8 = 9'd0;
        end else begin
            chk("busy_done_excl8", {31'd0, busy8 & done8}, 32'd0);
            if (done8) begin
                if (q8.size() == 0) begin
                    chk("unexpected_done8", 32'd1, 32'd0);
                end else begin
                    held8 = q8.pop_front();
                    chk("result8", {23'd0, cout8, sum8}, {23'd0, held8});
                end
            end else begin
                chk("hold8", {23'd0, cout8, sum8}, {23'd0, held8});
            end
        end
    end

    // WIDTH=5 monitor
    always @(negedge clk) begin
        if (!rst_n) begin
            held5 = 6'd0;
        end else begin
            chk("busy_done_excl5", {31'd0, busy5 & done5}, 32'd0);
            if (done5) begin
                if (q5.size() == 0) begin
                    chk("unexpected_done5", 32'd1, 32'd0);
                end else begin
                    held5 = q5.pop_front();
                    chk("result5", {26'd0, cout5, sum5}, {26'd0, held5});
                end
            end else begin
                chk("hold5", {26'd0, cout5, sum5}, {26'd0, held5});
            end
        end
    end

    // Issue one WIDTH=8 add; checks busy each bit cycle and done latency of 8
    task automatic op8(input logic [7:0] av, input logic [7:0] bv, input logic ci,
                       input logic [8:0] exp);
        int n;
        @(posedge clk); #1;
        start8 = 1'b1; a8 = av; b8 = bv; cin8 = ci;
        q8.push_back(exp);
        @(posedge clk); #1;
        start8 = 1'b0; a8 = 8'h00; b8 = 8'h00; cin8 = 1'b0;
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
            if (!done8) chk("busy_during_shift8", {31'd0, busy8}, 32'd1);
        end while (!done8 && n < 12);
        chk("latency8", n, 32'd8);
    endtask

    task automatic op5(input logic [4:0] av, input logic [4:0] bv, input logic ci,
                       input logic [5:0] exp);
        int n;
        @(posedge clk); #1;
        start5 = 1'b1; a5 = av; b5 = bv; cin5 = ci;
        q5.push_back(exp);
        @(posedge clk); #1;
        start5 = 1'b0;
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!done5 && n < 10);
        chk("latency5", n, 32'd5);
    endtask

    initial begin
        int n;
        logic [7:0] ra, rb;
        logic [4:0] ra5, rb5;
        logic       rc;

        rst_n = 1'b0;
        start8 = 1'b0; a8 = 8'h00; b8 = 8'h00; cin8 = 1'b0;
        start5 = 1'b0; a5 = 5'h00; b5 = 5'h00; cin5 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_state8", {22'd0, busy8, done8, cout8, sum8}, 32'd0);
        chk("reset_state5", {25'd0, busy5, done5, cout5, sum5}, 32'd0);
        rst_n = 1'b1;

        // Directed vectors
        op8(8'h5A, 8'h3C, 1'b0, 9'h096);
        op8(8'hFF, 8'h01, 1'b0, 9'h100);
        op8(8'hFF, 8'hFF, 1'b1, 9'h1FF);
        op8(8'h00, 8'h00, 1'b1, 9'h001);

        // start pulsed mid-SHIFT must be ignored
        @(posedge clk); #1;
        start8 = 1'b1; a8 = 8'h10; b8 = 8'h20; cin8 = 1'b0;
        q8.push_back(9'h030);
        @(posedge clk); #1;
        start8 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        start8 = 1'b1; a8 = 8'hAA; b8 = 8'h55;
        @(posedge clk); #1;
        start8 = 1'b0;
        n = 0;
        while (!done8 && n < 12) begin
            @(posedge clk); #1;
            n++;
        end
        chk("ignored_start_done_seen", {31'd0, done8}, 32'd1);
        repeat (12) @(posedge clk);
        #1;

        // Back-to-back with start held high
        start8 = 1'b1; a8 = 8'h01; b8 = 8'h02; cin8 = 1'b0;
        q8.push_back(9'h003);
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!done8 && n < 14);
        chk("b2b_first_done", {31'd0, done8}, 32'd1);
        a8 = 8'h7F; b8 = 8'h01;
        q8.push_back(9'h080);
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
            if (n == 1) start8 = 1'b0;
        end while (!done8 && n < 14);
        chk("b2b_spacing", n, 32'd9);
        @(posedge clk); #1;
        chk("done_one_cycle", {31'd0, done8}, 32'd0);

        // Asynchronous reset mid-SHIFT abandons the operation
        @(posedge clk); #1;
        start8 = 1'b1; a8 = 8'hF0; b8 = 8'h0F; cin8 = 1'b0;
        @(posedge clk); #1;
        start8 = 1'b0;
        repeat (3) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("async_reset_outputs", {22'd0, busy8, done8, cout8, sum8}, 32'd0);
        @(negedge clk);
        @(posedge clk); #3;
        rst_n = 1'b1;
        repeat (12) @(posedge clk);
        op8(8'h01, 8'h01, 1'b0, 9'h002);

        // Random operations, both widths
        for (int i = 0; i < 300; i++) begin
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(0, 255));
            rc = 1'($urandom_range(0, 1));
            op8(ra, rb, rc, 9'(ra) + 9'(rb) + 9'(rc));
        end
        for (int i = 0; i < 200; i++) begin
            ra5 = 5'($urandom_range(0, 31));
            rb5 = 5'($urandom_range(0, 31));
            rc  = 1'($urandom_range(0, 1));
            op5(ra5, rb5, rc, 6'(ra5) + 6'(rb5) + 6'(rc));
        end

        repeat (4) @(posedge clk);
        #1;
        chk("queue8_drained", q8.size(), 32'd0);
        chk("queue5_drained", q5.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_serial_adder
